// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection with a
// single-entry redirect buffer, and the Fetch/Decode pipeline register.
module fetch_stage #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             FlushD,
   input  logic             BranchTakenE,
   input  logic [WIDTH-1:0] ALUResultE,
   input  logic             PCSrcW,
   input  logic [WIDTH-1:0] ResultW,
   input  logic [31:0]      InstrF,
   output logic [WIDTH-1:0] PCF,
   output logic [WIDTH-1:0] PCPlus4F,
   output logic [31:0]      InstrD,
   output logic [WIDTH-1:0] PCPlus8D,
   output logic             ValidD
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             pend_v_q, pend_v_d;
   logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
   logic [31:0]      instr_d_q, instr_d_d;
   logic [WIDTH-1:0] pc_plus8_d_q, pc_plus8_d_d;
   logic             vld_d_q, vld_d_d;

   logic             redir;
   logic [WIDTH-1:0] redir_pc;
   logic [WIDTH-1:0] pc_plus4;

   assign pc_plus4 = pc_q + WIDTH'(4);

   // Execute-stage branch outranks a Writeback PC write; targets are word aligned.
   always_comb begin
      redir    = BranchTakenE | PCSrcW;
      redir_pc = BranchTakenE ? ALUResultE : ResultW;
      redir_pc[1:0] = 2'b00;
   end

   always_comb begin
      pc_d      = pc_q;
      pend_v_d  = pend_v_q;
      pend_pc_d = pend_pc_q;
      if (StallF) begin
         if (redir) begin
            pend_v_d  = 1'b1;
            pend_pc_d = redir_pc;
         end
      end else begin
         pend_v_d = 1'b0;
         if (redir)
            pc_d = redir_pc;
         else if (pend_v_q)
            pc_d = pend_pc_q;
         else
            pc_d = pc_plus4;
      end
   end

   // The word fetched while a redirect is pending is on the wrong path.
   always_comb begin
      instr_d_d    = instr_d_q;
      pc_plus8_d_d = pc_plus8_d_q;
      vld_d_d      = vld_d_q;
      if (FlushD) begin
         instr_d_d    = 32'h0;
         pc_plus8_d_d = '0;
         vld_d_d      = 1'b0;
      end else if (!StallD) begin
         instr_d_d    = InstrF;
         pc_plus8_d_d = pc_q + WIDTH'(8);
         vld_d_d      = ~pend_v_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q         <= RESET_PC;
         pend_v_q     <= 1'b0;
         pend_pc_q    <= '0;
         instr_d_q    <= 32'h0;
         pc_plus8_d_q <= '0;
         vld_d_q      <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         pend_v_q     <= pend_v_d;
         pend_pc_q    <= pend_pc_d;
         instr_d_q    <= instr_d_d;
         pc_plus8_d_q <= pc_plus8_d_d;
         vld_d_q      <= vld_d_d;
      end
   end

   assign PCF      = pc_q;
   assign PCPlus4F = pc_plus4;
   assign InstrD   = instr_d_q;
   assign PCPlus8D = pc_plus8_d_q;
   assign ValidD   = vld_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns addr>>2.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        StallF, StallD, FlushD;
   logic        BranchTakenE, PCSrcW;
   logic [31:0] ALUResultE, ResultW;
   logic [31:0] InstrF;
   logic [31:0] PCF, PCPlus4F, InstrD, PCPlus8D;
   logic        ValidD;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign InstrF = {2'b00, PCF[31:2]};

   fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset_n(reset_n),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
      .PCSrcW(PCSrcW), .ResultW(ResultW),
      .InstrF(InstrF),
      .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrD(InstrD),
      .PCPlus8D(PCPlus8D), .ValidD(ValidD)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      StallF = 0; StallD = 0; FlushD = 0;
      BranchTakenE = 0; PCSrcW = 0;
      ALUResultE = 32'h0; ResultW = 32'h0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 0;
      step();
      checks++; if (PCF !== 32'h0) begin failures++; $display("FAIL rst_pcf got=%h exp=%h", PCF, 32'h0); end
      checks++; if (ValidD !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ValidD); end
      checks++; if (InstrD !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", InstrD); end
      checks++; if (PCPlus8D !== 32'h0) begin failures++; $display("FAIL rst_pc8 got=%h exp=0", PCPlus8D); end
      checks++; if (PCPlus4F !== 32'h4) begin failures++; $display("FAIL rst_pc4f got=%h exp=4", PCPlus4F); end
      #3 reset_n = 1;
      step();
      checks++; if (PCF !== 32'h4) begin failures++; $display("FAIL seq_pcf1 got=%h exp=4", PCF); end
      checks++; if (InstrD !== 32'h0 || ValidD !== 1'b1) begin failures++; $display("FAIL seq_instr0 got=%h/%b exp=0/1", InstrD, ValidD); end
      checks++; if (PCPlus8D !== 32'h8) begin failures++; $display("FAIL seq_pc8_0 got=%h exp=8", PCPlus8D); end
      step();
      checks++; if (PCF !== 32'h8) begin failures++; $display("FAIL seq_pcf2 got=%h exp=8", PCF); end
      checks++; if (InstrD !== 32'h1 || ValidD !== 1'b1) begin failures++; $display("FAIL seq_instr1 got=%h/%b exp=1/1", InstrD, ValidD); end
      step();
      checks++; if (PCF !== 32'hC) begin failures++; $display("FAIL seq_pcf3 got=%h exp=c", PCF); end
      checks++; if (InstrD !== 32'h2 || PCPlus8D !== 32'h10) begin failures++; $display("FAIL seq_instr2 got=%h/%h exp=2/10", InstrD, PCPlus8D); end
      step();
   endtask

   task automatic test_load_use();
      checks++; if (PCF !== 32'h10 || InstrD !== 32'h3) begin failures++; $display("FAIL lu_start got=%h/%h exp=10/3", PCF, InstrD); end
      StallF = 1; StallD = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (PCF !== 32'h10 || InstrD !== 32'h3 || ValidD !== 1'b1) begin failures++; $display("FAIL lu_hold%0d got=%h/%h/%b exp=10/3/1", i, PCF, InstrD, ValidD); end
      end
      StallF = 0; StallD = 0;
      step();
      checks++; if (PCF !== 32'h14 || InstrD !== 32'h4 || ValidD !== 1'b1) begin failures++; $display("FAIL lu_resume got=%h/%h/%b exp=14/4/1", PCF, InstrD, ValidD); end
   endtask

   task automatic test_branch();
      step(); step(); step();
      checks++; if (PCF !== 32'h20) begin failures++; $display("FAIL br_start got=%h exp=20", PCF); end
      BranchTakenE = 1; ALUResultE = 32'h100; FlushD = 1;
      step();
      clear_inputs();
      checks++; if (PCF !== 32'h100) begin failures++; $display("FAIL br_pcf got=%h exp=100", PCF); end
      checks++; if (InstrD !== 32'h0 || ValidD !== 1'b0 || PCPlus8D !== 32'h0) begin failures++; $display("FAIL br_flush got=%h/%b/%h exp=0/0/0", InstrD, ValidD, PCPlus8D); end
      step();
      checks++; if (InstrD !== 32'h40 || ValidD !== 1'b1 || PCPlus8D !== 32'h108) begin failures++; $display("FAIL br_target got=%h/%b/%h exp=40/1/108", InstrD, ValidD, PCPlus8D); end
      checks++; if (PCF !== 32'h104) begin failures++; $display("FAIL br_next got=%h exp=104", PCF); end
   endtask

   task automatic test_priority();
      BranchTakenE = 1; ALUResultE = 32'h200; PCSrcW = 1; ResultW = 32'h300;
      step();
      clear_inputs();
      checks++; if (PCF !== 32'h200) begin failures++; $display("FAIL prio_pcf got=%h exp=200", PCF); end
      PCSrcW = 1; ResultW = 32'h303;
      step();
      clear_inputs();
      checks++; if (PCF !== 32'h300) begin failures++; $display("FAIL align_pcf got=%h exp=300", PCF); end
   endtask

   task automatic test_deferred();
      StallF = 1; StallD = 1; PCSrcW = 1; ResultW = 32'h400;
      step();
      checks++; if (PCF !== 32'h300) begin failures++; $display("FAIL def_hold1 got=%h exp=300", PCF); end
      ResultW = 32'h500;
      step();
      checks++; if (PCF !== 32'h300) begin failures++; $display("FAIL def_hold2 got=%h exp=300", PCF); end
      clear_inputs();
      step();
      checks++; if (PCF !== 32'h500) begin failures++; $display("FAIL def_pcf got=%h exp=500", PCF); end
      checks++; if (ValidD !== 1'b0 || InstrD !== 32'hC0) begin failures++; $display("FAIL def_valid got=%b/%h exp=0/c0", ValidD, InstrD); end
      checks++; if (dut.pend_v_q !== 1'b0) begin failures++; $display("FAIL def_pendv got=%b exp=0", dut.pend_v_q); end
      step();
      checks++; if (PCF !== 32'h504 || InstrD !== 32'h140 || ValidD !== 1'b1) begin failures++; $display("FAIL def_after got=%h/%h/%b exp=504/140/1", PCF, InstrD, ValidD); end
      // pending target loses to a live redirect on release
      StallF = 1; StallD = 1; PCSrcW = 1; ResultW = 32'h600;
      step();
      clear_inputs();
      BranchTakenE = 1; ALUResultE = 32'h700;
      step();
      clear_inputs();
      checks++; if (PCF !== 32'h700) begin failures++; $display("FAIL live_win got=%h exp=700", PCF); end
      step();
      checks++; if (PCF !== 32'h704 || ValidD !== 1'b1) begin failures++; $display("FAIL live_clear got=%h/%b exp=704/1", PCF, ValidD); end
   endtask

   task automatic test_async_reset();
      StallF = 1; StallD = 1; PCSrcW = 1; ResultW = 32'h400;
      step();
      PCSrcW = 0;
      checks++; if (dut.pend_v_q !== 1'b1) begin failures++; $display("FAIL ar_pend_set got=%b exp=1", dut.pend_v_q); end
      #2 reset_n = 0;
      #1;
      checks++; if (PCF !== 32'h0 || ValidD !== 1'b0) begin failures++; $display("FAIL ar_now got=%h/%b exp=0/0", PCF, ValidD); end
      checks++; if (InstrD !== 32'h0 || PCPlus8D !== 32'h0) begin failures++; $display("FAIL ar_regs got=%h/%h exp=0/0", InstrD, PCPlus8D); end
      checks++; if (dut.pend_v_q !== 1'b0) begin failures++; $display("FAIL ar_pendv got=%b exp=0", dut.pend_v_q); end
      clear_inputs();
      #1 reset_n = 1;
      step();
      checks++; if (PCF !== 32'h4 || ValidD !== 1'b1 || InstrD !== 32'h0) begin failures++; $display("FAIL ar_release got=%h/%b/%h exp=4/1/0", PCF, ValidD, InstrD); end
   endtask

   task automatic test_wrap();
      BranchTakenE = 1; ALUResultE = 32'hFFFF_FFFC;
      step();
      clear_inputs();
      checks++; if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin failures++; $display("FAIL wrap_pre got=%h/%h exp=fffffffc/0", PCF, PCPlus4F); end
      step();
      checks++; if (PCF !== 32'h0) begin failures++; $display("FAIL wrap_pcf got=%h exp=0", PCF); end
      checks++; if (InstrD !== 32'h3FFF_FFFF || PCPlus8D !== 32'h4) begin failures++; $display("FAIL wrap_fd got=%h/%h exp=3fffffff/4", InstrD, PCPlus8D); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_priority();
      test_deferred();
      test_async_reset();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
